// File: rtl/controle_irrigacao.sv
// rtl/controle_irrigacao.sv - irrigation sequencing controller with BCD mm:ss countdown
//
// Optional feature macro: VALIDA_BCD_EN (rejects non-BCD presets at load time).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   iniciar, parar, pausa       start request, abort, hold (levels)
//   aspersao, gotejamento       mode select, exactly one high to start
//   niveis[2:0]                 soil moisture level
//   *preset[3:0]                BCD preset digits mm:ss
//   dez_minuto..unid_segundo    remaining time, BCD
//   valvula_aspersao, valvula_gotejamento, bomba   actuator enables
//   ocupado                     state is not OCIOSO
//   fim, erro                   completion / refused-start pulses
//   estado[2:0]                 current state code
module controle_irrigacao #(
  parameter int         CLK_HZ         = 50_000_000,
  parameter logic [2:0] NIVEL_SATURADO = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       pausa,
  input  logic       aspersao,
  input  logic       gotejamento,
  input  logic [2:0] niveis,
  input  logic [3:0] dez_minutopreset,
  input  logic [3:0] unid_minutopreset,
  input  logic [3:0] dez_segundopreset,
  input  logic [3:0] unid_segundopreset,
  output logic [3:0] dez_minuto,
  output logic [3:0] unid_minuto,
  output logic [3:0] dez_segundo,
  output logic [3:0] unid_segundo,
  output logic       valvula_aspersao,
  output logic       valvula_gotejamento,
  output logic       bomba,
  output logic       ocupado,
  output logic       fim,
  output logic       erro,
  output logic [2:0] estado
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CARREGA   = 3'd1,
    IRRIGANDO = 3'd2,
    PAUSA     = 3'd3,
    CONCLUIDO = 3'd4
  } estado_t;

  estado_t       state_q, state_d;
  logic          modo_q, modo_d;   // 1 = aspersao, 0 = gotejamento
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    dm_q, dm_d, um_q, um_d, ds_q, ds_d, us_q, us_d;
  logic          val_asp_q, val_asp_d, val_got_q, val_got_d;
  logic          bomba_q, bomba_d, fim_q, fim_d, erro_q, erro_d;

  logic       saturado, tick, dec_zero, preset_zero, bcd_invalido;
  logic [3:0] dm_n, um_n, ds_n, us_n;

  assign saturado    = (niveis >= NIVEL_SATURADO);
  assign tick        = (presc_q == PRESC_MAX);
  assign preset_zero = ({dez_minutopreset, unid_minutopreset,
                         dez_segundopreset, unid_segundopreset} == 16'h0000);

`ifdef VALIDA_BCD_EN
  assign bcd_invalido = (dez_minutopreset > 4'd9) || (unid_minutopreset > 4'd9) ||
                        (dez_segundopreset > 4'd5) || (unid_segundopreset > 4'd9);
`else
  assign bcd_invalido = 1'b0;
`endif

  // One-second BCD decrement; a zero digit reloads its maximum and borrows upward.
  // Non-BCD digits (only loadable without validation) simply count down.
  always_comb begin
    dm_n = dm_q;
    um_n = um_q;
    ds_n = ds_q;
    us_n = us_q;
    if (us_q != 4'd0) begin
      us_n = us_q - 4'd1;
    end else begin
      us_n = 4'd9;
      if (ds_q != 4'd0) begin
        ds_n = ds_q - 4'd1;
      end else begin
        ds_n = 4'd5;
        if (um_q != 4'd0) begin
          um_n = um_q - 4'd1;
        end else begin
          um_n = 4'd9;
          dm_n = dm_q - 4'd1;
        end
      end
    end
    dec_zero = ({dm_n, um_n, ds_n, us_n} == 16'h0000);
  end

  always_comb begin
    state_d = state_q;
    modo_d  = modo_q;
    presc_d = presc_q;
    dm_d    = dm_q;
    um_d    = um_q;
    ds_d    = ds_q;
    us_d    = us_q;
    erro_d  = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (iniciar) begin
          if ((aspersao ^ gotejamento) && !saturado) begin
            modo_d  = aspersao;
            state_d = CARREGA;
          end else begin
            erro_d = 1'b1;
          end
        end
      end

      CARREGA: begin
        if (parar) begin
          state_d = OCIOSO;
        end else if (bcd_invalido) begin
          erro_d  = 1'b1;
          state_d = OCIOSO;
        end else begin
          dm_d    = dez_minutopreset;
          um_d    = unid_minutopreset;
          ds_d    = dez_segundopreset;
          us_d    = unid_segundopreset;
          presc_d = '0;
          state_d = preset_zero ? CONCLUIDO : IRRIGANDO;
        end
      end

      IRRIGANDO: begin
        if (parar) begin
          state_d = OCIOSO;
        end else if (saturado) begin
          state_d = CONCLUIDO;
        end else begin
          // The cycle in which pausa is first seen still counts as irrigation,
          // so the prescaler advances before the hold takes effect.
          if (tick) begin
            presc_d = '0;
            dm_d    = dm_n;
            um_d    = um_n;
            ds_d    = ds_n;
            us_d    = us_n;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (tick && dec_zero) begin
            state_d = CONCLUIDO;
          end else if (pausa) begin
            state_d = PAUSA;
          end
        end
      end

      PAUSA: begin
        if (parar) begin
          state_d = OCIOSO;
        end else if (saturado) begin
          state_d = CONCLUIDO;
        end else if (!pausa) begin
          state_d = IRRIGANDO;
        end
      end

      CONCLUIDO: state_d = OCIOSO;

      default: state_d = OCIOSO;
    endcase

    // Actuators follow the next state so they switch on the edge that enters/leaves IRRIGANDO.
    bomba_d   = (state_d == IRRIGANDO);
    val_asp_d = (state_d == IRRIGANDO) &&  modo_d;
    val_got_d = (state_d == IRRIGANDO) && !modo_d;
    fim_d     = (state_d == CONCLUIDO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= OCIOSO;
      modo_q    <= 1'b0;
      presc_q   <= '0;
      dm_q      <= 4'd0;
      um_q      <= 4'd0;
      ds_q      <= 4'd0;
      us_q      <= 4'd0;
      val_asp_q <= 1'b0;
      val_got_q <= 1'b0;
      bomba_q   <= 1'b0;
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      modo_q    <= modo_d;
      presc_q   <= presc_d;
      dm_q      <= dm_d;
      um_q      <= um_d;
      ds_q      <= ds_d;
      us_q      <= us_d;
      val_asp_q <= val_asp_d;
      val_got_q <= val_got_d;
      bomba_q   <= bomba_d;
      fim_q     <= fim_d;
      erro_q    <= erro_d;
    end
  end

  assign dez_minuto          = dm_q;
  assign unid_minuto         = um_q;
  assign dez_segundo         = ds_q;
  assign unid_segundo        = us_q;
  assign valvula_aspersao    = val_asp_q;
  assign valvula_gotejamento = val_got_q;
  assign bomba               = bomba_q;
  assign fim                 = fim_q;
  assign erro                = erro_q;
  assign estado              = state_q;
  assign ocupado             = (state_q != OCIOSO);

endmodule

// File: doc/controle_irrigacao.md
# controle_irrigacao

Sequencing controller for the automated-irrigation datapath. Latches the irrigation mode, loads the four BCD preset digits (mm:ss) produced by the preset generator, and counts them down once per second while driving the sprinkler or drip valve and the pump. It stops on timeout, soil saturation or operator abort, and exposes the remaining time to the display logic.

## Interface
- CLK_HZ, 50_000_000: clock frequency; the internal prescaler produces one decrement every CLK_HZ cycles.
- NIVEL_SATURADO, 3'b111: `niveis` value at or above which the soil counts as saturated.
- clk  in  1  system clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  start request; level, sampled only in OCIOSO.
- parar  in  1  abort; level.
- pausa  in  1  hold irrigation; level.
- aspersao, gotejamento  in  1 each  mode select; exactly one must be high to start.
- niveis  in  3  soil moisture level.
- dez_minutopreset, unid_minutopreset, dez_segundopreset, unid_segundopreset  in  4 each  BCD preset.
- dez_minuto, unid_minuto, dez_segundo, unid_segundo  out  4 each  remaining time, BCD.
- valvula_aspersao, valvula_gotejamento, bomba  out  1 each  actuator enables.
- ocupado  out  1  high whenever state ≠ OCIOSO.
- fim  out  1  one-cycle pulse on normal completion.
- erro  out  1  one-cycle pulse on a refused start.
- estado  out  3  current state code.

## Operation
- States and codes:
  - OCIOSO = 0
  - CARREGA = 1
  - IRRIGANDO = 2
  - PAUSA = 3
  - CONCLUIDO = 4
- Reset value of every output: all outputs 0 and state OCIOSO. This includes remaining-time digits = 00:00.
- OCIOSO: when `iniciar`=1 and (`aspersao` XOR `gotejamento`)=1 and `niveis` < NIVEL_SATURADO, latch the mode bit and go to CARREGA.
  - `iniciar`=1 with any of those conditions false: pulse `erro` and stay in OCIOSO.
- CARREGA (one cycle): copy the four preset digits into the counters and clear the prescaler.
  - If the preset is 00:00, go to CONCLUIDO.
  - Otherwise go to IRRIGANDO.
- IRRIGANDO:
  - `bomba`=1.
  - The valve of the latched mode is 1; the other valve is 0.
  - The prescaler increments every cycle. At CLK_HZ−1 it wraps and decrements the time by one second.
- Decrement is BCD with borrow through all four digits:
  - unid_segundo: 0→9 and borrow.
  - dez_segundo: 0→5 and borrow.
  - unid_minuto: 0→9 and borrow.
  - dez_minuto: decrement.
- On a decrement that produces 00:00, go to CONCLUIDO on the same edge.
- PAUSA:
  - Valves and pump are 0.
  - The prescaler and digits hold.
  - `pausa`=0 returns to IRRIGANDO; the prescaler resumes from its held value.
- CONCLUIDO (one cycle): `fim`=1, all actuators 0, then OCIOSO. Digits keep their final value until the next load.
- Priority in IRRIGANDO and PAUSA, highest first:
  1. `reset`
  2. `parar`: next state OCIOSO, no `fim`, digits frozen.
  3. Saturation: `niveis` ≥ NIVEL_SATURADO gives CONCLUIDO, with `fim`.
  4. Countdown reaching 00:00.
  5. `pausa`.
- `parar` in CARREGA gives OCIOSO.
- Mode inputs are ignored after the latch; changing them mid-run has no effect.

## Timing
- `iniciar` sampled at edge N gives `ocupado`=1 after N.
- Valve and pump assert after edge N+1; this is the IRRIGANDO entry.
- The first decrement occurs CLK_HZ cycles after IRRIGANDO entry.
- Preset mm:ss ≠ 0 with no pause gives exactly (60·mm+ss)·CLK_HZ cycles in IRRIGANDO. `fim` then asserts for the following cycle.
- Actuators are registered; they deassert on the same edge that leaves IRRIGANDO.
- `reset` mid-run clears everything on the next edge.

## Configuration
- VALIDA_BCD_EN defined:
  - In CARREGA, if any digit is > 9 or dez_segundopreset is > 5, pulse `erro`, return to OCIOSO, and leave actuators at 0.
  - The counters are not loaded in that case.
- VALIDA_BCD_EN undefined:
  - Digits are loaded unchecked.
  - Invalid digits still count down via the borrow rules above.

## Test plan
- Test parameters: CLK_HZ=4, NIVEL_SATURADO=3'b111.
- Normal aspersão run: preset 00:03, aspersao=1, iniciar pulse → 
  - valvula_aspersao=1 for exactly 12 cycles;
  - digits step 03→02→01→00;
  - fim pulses once;
  - estado returns to 0.
- Borrow chain: preset 10:00, gotejamento=1 → after the first decrement, digits are 09:59.
  - Only valvula_gotejamento is high.
- Refused start: each of the following gives `erro` pulse and `ocupado` stays 0:
  - aspersao=gotejamento=1;
  - neither mode selected;
  - niveis=3'b111 at iniciar.
- Pause and abort: preset 00:05.
  - pausa for 10 cycles at 00:04: actuators 0, digits hold, then resume; total IRRIGANDO time = 20 cycles.
  - parar at 00:02: OCIOSO next cycle, no fim, digits show 00:02.
- Saturation and zero preset:
  - niveis driven to 3'b111 during a 00:05 run → CONCLUIDO next edge, fim=1, digits frozen.
  - Preset 00:00 → fim 2 cycles after iniciar, actuators never asserted.
- VALIDA_BCD_EN: preset unid_segundopreset=4'hA → erro, no actuators (with macro); without macro the counter loads A.
